imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Instruction-fetch sequencer for the byte-wide, 256-entry instruction memory. Owns the program counter, reads each 16-bit instruction as two consecutive bytes (high byte at PC, low byte at PC+1), and presents it to decode over a valid/ready handshake. It also arbitrates the memory's single address port between fetch and a byte-serial program loader, and handles PC redirects from branch/jump logic.

## Interface
- ADDR_W, 8, PC and memory address width; memory depth is 2^ADDR_W bytes.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  fetch enable; 0 parks the sequencer in IDLE at an instruction boundary.
- mem_addr  out  ADDR_W  byte address to the instruction memory.
- mem_rdata  in  8  memory read data, combinational from mem_addr in the same cycle.
- mem_we  out  1  byte write strobe to the memory.
- mem_wdata  out  8  byte write data.
- redirect_valid  in  1  load a new PC and discard any in-flight fetch.
- redirect_pc  in  ADDR_W  redirect target.
- instr_valid  out  1  instr, instr_pc hold a complete instruction.
- instr_ready  in  1  decode accepts the instruction.
- instr  out  16  {high byte, low byte}.
- instr_pc  out  ADDR_W  address of instr's high byte.
- ld_valid  in  1  loader write request.
- ld_ready  out  1  loader write performed this cycle.
- ld_addr  in  ADDR_W  loader byte address.
- ld_data  in  8  loader byte.

## Operation
- States: IDLE, HI, LO, HOLD.
- IDLE: mem_addr=pc. If ld_valid: mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data, ld_ready=1; stay IDLE. Else if run: go HI. Else stay.
- HI: mem_addr=pc; capture mem_rdata into instr[15:8]; go LO.
- LO: mem_addr=pc+1 (mod 2^ADDR_W); capture mem_rdata into instr[7:0]; instr_pc<=pc; go HOLD.
- HOLD: instr_valid=1; instr, instr_pc stable. On instr_ready: pc<=pc+2 (mod 2^ADDR_W); go IDLE if ld_valid or !run, else HI.
- Loader has priority only at instruction boundaries (IDLE); a HI/LO pair is never split. Fetch starves while ld_valid stays high in IDLE.
- Redirect (any state): pc<=redirect_pc; next state HI if run and !ld_valid, else IDLE; instr_valid deasserts next cycle. In IDLE with ld_valid and redirect together, the write is performed and the PC is redirected.
- Redirect and instr_ready together in HOLD: handshake completes (instruction consumed); pc<=redirect_pc, not pc+2.
- Odd PCs are legal; PC=8'hFF reads bytes FF then 00. PC wraps FF->01 on increment from FF.
- mem_we is 1 only in IDLE with ld_valid; 0 in all other states.

## Timing
- Reset values: state IDLE, pc=RESET_PC, instr=16'h0000, instr_pc=8'h00, instr_valid=0, ld_ready=0, mem_we=0, mem_wdata=0, mem_addr=RESET_PC.
- Reset asserted mid-fetch aborts immediately; partial instruction discarded.
- Fetch latency: IDLE->HI->LO->HOLD; instr_valid asserts 3 cycles after run rises in IDLE.
- Throughput with instr_ready held high: one instruction per 3 cycles (HI, LO, HOLD).
- ld_ready and mem_we are combinational in the same cycle as ld_valid in IDLE; loader throughput one byte per cycle.
- instr, instr_pc must not change while instr_valid=1 and instr_ready=0.

## Configuration
- IFETCH_LOADER_EN defined: loader ports present and arbitration as above.
- Not defined: ld_valid, ld_ready, ld_addr, ld_data ports absent; mem_we and mem_wdata tied to 0; IDLE leaves only on run; memory contents come from initialization only.

## Test plan
- Reset, memory {00:01,01:18,02:12,03:24}, run=1, instr_ready=1 -> instr 16'h0118 at pc 00, then 16'h1224 at pc 02, instr_valid first high 3 cycles after reset release.
- instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc constant, pc unchanged, no memory reads beyond LO.
- redirect_valid with redirect_pc=8'h40 during LO -> in-flight fetch dropped, next instr_pc=8'h40; redirect coincident with accept in HOLD -> pc=8'h40, not pc+2.
- PC=8'hFF, memory FF:AB, 00:CD -> instr=16'hABCD, instr_pc=8'hFF, next pc=8'h01.
- (IFETCH_LOADER_EN) run=0, load bytes 10:55, 11:66 -> ld_ready high each cycle, mem_we pulses; then redirect to 10, run=1 -> instr 16'h5566.
- (IFETCH_LOADER_EN) ld_valid asserted during HI -> no write until HOLD accept returns to IDLE; HI/LO pair completes unsplit.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer for a byte-wide instruction memory.
// Reads each 16-bit instruction as two bytes (high at PC, low at PC+1), hands it
// to decode over valid/ready, and shares the memory port with a byte loader.
// Optional feature macro: IFETCH_LOADER_EN (loader ports and write arbitration).
module imem_fetch_ctrl #(
  parameter int unsigned        ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr,
`ifdef IFETCH_LOADER_EN
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
`endif
  output logic [ADDR_W-1:0] instr_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt;
  logic [15:0]         instr_nxt;
  logic [ADDR_W-1:0]   instr_pc_nxt;

  logic                ld_req;
  logic [ADDR_W-1:0]   ld_a;
  logic [7:0]          ld_d;
  logic                ld_grant;

  // Loader request view; without the loader nothing ever requests the port.
`ifdef IFETCH_LOADER_EN
  assign ld_req   = ld_valid;
  assign ld_a     = ld_addr;
  assign ld_d     = ld_data;
  assign ld_ready = ld_grant;
`else
  assign ld_req   = 1'b0;
  assign ld_a     = '0;
  assign ld_d     = '0;
`endif

  // A held instruction is exactly the HOLD state.
  assign instr_valid = (state == HOLD);

  // State, PC and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= 16'h0000;
      instr_pc <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instr    <= instr_nxt;
      instr_pc <= instr_pc_nxt;
    end
  end

  // Next-state, memory port arbitration and byte capture.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    mem_addr     = pc;
    mem_we       = 1'b0;
    mem_wdata    = 8'h00;
    ld_grant     = 1'b0;

    case (state)
      IDLE: begin
        if (ld_req) begin
          mem_we    = 1'b1;
          mem_addr  = ld_a;
          mem_wdata = ld_d;
          ld_grant  = 1'b1;
        end else if (run) begin
          state_nxt = HI;
        end
      end
      HI: begin
        instr_nxt[15:8] = mem_rdata;
        state_nxt       = LO;
      end
      LO: begin
        mem_addr       = pc + ADDR_W'(1);
        instr_nxt[7:0] = mem_rdata;
        instr_pc_nxt   = pc;
        state_nxt      = HOLD;
      end
      HOLD: begin
        if (instr_ready) begin
          pc_nxt    = pc + ADDR_W'(2);
          state_nxt = (ld_req || !run) ? IDLE : HI;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides the sequence and drops any partial fetch.
    if (redirect_valid) begin
      pc_nxt    = redirect_pc;
      state_nxt = (run && !ld_req) ? HI : IDLE;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level model of the fetch stream.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
`ifdef IFETCH_LOADER_EN
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
`endif

  logic [7:0]  mem [256];
  logic        bk_we;
  logic [7:0]  bk_addr;
  logic [7:0]  bk_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
`ifdef IFETCH_LOADER_EN
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
`endif
    .instr_pc       (instr_pc)
  );

  // Behavioural byte memory: combinational read, write on the clock edge.
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (bk_we) mem[bk_addr] <= bk_data;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bk_we   = 1'b1;
    bk_addr = a;
    bk_data = d;
    tick();
    bk_we   = 1'b0;
  endtask

  // Counts cycles until instr_valid, bounded so a stuck DUT still ends the run.
  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, 16'(n), 16'(exp_lat));
  endtask

  task automatic idle_inputs();
    run            = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
`ifdef IFETCH_LOADER_EN
    ld_valid       = 1'b0;
    ld_addr        = 8'h00;
    ld_data        = 8'h00;
`endif
  endtask

  initial begin
    logic [7:0]  exp_pc;
    logic [7:0]  nxt_a;
    logic [15:0] exp_instr;
    int          n_acc;

    rst_n = 1'b0;
    bk_we = 1'b0;
    bk_addr = 8'h00;
    bk_data = 8'h00;
    idle_inputs();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // ---- basic fetch stream, stall, redirects ----
    poke(8'h00, 8'h01); poke(8'h01, 8'h18); poke(8'h02, 8'h12); poke(8'h03, 8'h24);
    poke(8'h04, 8'h77); poke(8'h05, 8'h88); poke(8'h40, 8'h9A); poke(8'h41, 8'hBC);
    check("rst_valid", 16'(instr_valid), 16'h0);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", 16'(instr_pc), 16'h00);
    check("rst_mem_addr", 16'(mem_addr), 16'h00);
    check("rst_mem_we", 16'(mem_we), 16'h0);
    check("rst_mem_wdata", 16'(mem_wdata), 16'h00);

    run = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
    wait_valid("first_latency", 3);
    check("first_instr", instr, 16'h0118);
    check("first_pc", 16'(instr_pc), 16'h00);
    tick();
    check("accept_drops_valid", 16'(instr_valid), 16'h0);
    wait_valid("second_latency", 2);
    check("second_instr", instr, 16'h1224);
    check("second_pc", 16'(instr_pc), 16'h02);

    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 16'(instr_valid), 16'h1);
      check("stall_instr", instr, 16'h1224);
      check("stall_pc", 16'(instr_pc), 16'h02);
    end
    instr_ready = 1'b1;
    tick();
    wait_valid("after_stall_latency", 2);
    check("after_stall_pc", 16'(instr_pc), 16'h04);
    check("after_stall_instr", instr, 16'h7788);

    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    wait_valid("redir_lo_latency", 2);
    check("redir_lo_pc", 16'(instr_pc), 16'h40);
    check("redir_lo_instr", instr, 16'h9ABC);

    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir_accept_drop", 16'(instr_valid), 16'h0);
    wait_valid("redir_accept_latency", 2);
    check("redir_accept_pc", 16'(instr_pc), 16'h40);

    // ---- PC wrap at the top of memory ----
    rst_n = 1'b0;
    idle_inputs();
    poke(8'hFF, 8'hAB); poke(8'h00, 8'hCD); poke(8'h01, 8'h11); poke(8'h02, 8'h22);
    rst_n = 1'b1;
    tick();
    check("idle_parked", 16'(instr_valid), 16'h0);
    redirect_valid = 1'b1; redirect_pc = 8'hFF; run = 1'b1;
    tick();
    redirect_valid = 1'b0;
    wait_valid("wrap_latency", 2);
    check("wrap_instr", instr, 16'hABCD);
    check("wrap_pc", 16'(instr_pc), 16'hFF);
    instr_ready = 1'b1;
    tick();
    wait_valid("wrap_next_latency", 2);
    check("wrap_next_pc", 16'(instr_pc), 16'h01);
    check("wrap_next_instr", instr, 16'h1122);

`ifdef IFETCH_LOADER_EN
    // ---- loader writes in IDLE, then fetch of the loaded bytes ----
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    ld_valid = 1'b1; ld_addr = 8'h10; ld_data = 8'h55;
    #1;
    check("ld0_ready", 16'(ld_ready), 16'h1);
    check("ld0_we", 16'(mem_we), 16'h1);
    check("ld0_addr", 16'(mem_addr), 16'h10);
    check("ld0_wdata", 16'(mem_wdata), 16'h55);
    tick();
    ld_addr = 8'h11; ld_data = 8'h66;
    #1;
    check("ld1_ready", 16'(ld_ready), 16'h1);
    check("ld1_addr", 16'(mem_addr), 16'h11);
    tick();
    ld_valid = 1'b0;
    #1;
    check("ld_done_we", 16'(mem_we), 16'h0);
    redirect_valid = 1'b1; redirect_pc = 8'h10; run = 1'b1;
    tick();
    redirect_valid = 1'b0;
    wait_valid("ld_fetch_latency", 2);
    check("ld_fetch_instr", instr, 16'h5566);

    // ---- loader request arriving mid-fetch waits for the boundary ----
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 8'h20; ld_data = 8'h5A;
    #1;
    check("ld_hi_ready", 16'(ld_ready), 16'h0);
    check("ld_hi_we", 16'(mem_we), 16'h0);
    tick();
    check("ld_lo_ready", 16'(ld_ready), 16'h0);
    tick();
    check("ld_hold_valid", 16'(instr_valid), 16'h1);
    check("ld_hold_instr", instr, 16'h5566);
    check("ld_hold_ready", 16'(ld_ready), 16'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("ld_boundary_ready", 16'(ld_ready), 16'h1);
    check("ld_boundary_we", 16'(mem_we), 16'h1);
    tick();
    ld_valid = 1'b0;
    check("ld_boundary_mem", 16'(mem[8'h20]), 16'h5A);
`endif

    // ---- randomized traffic against a transaction-level model ----
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    rst_n = 1'b1;
    exp_pc = 8'h00;
    n_acc = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      run            = ($urandom % 8) != 0;
      instr_ready    = ($urandom % 2) != 0;
      redirect_valid = ($urandom % 12) == 0;
      redirect_pc    = 8'($urandom);
`ifdef IFETCH_LOADER_EN
      ld_valid = ($urandom % 6) == 0;
      ld_addr  = 8'($urandom);
      ld_data  = 8'($urandom);
`endif
      #1;
      if (instr_valid) begin
        nxt_a     = exp_pc + 8'd1;
        exp_instr = {mem[exp_pc], mem[nxt_a]};
        check("rnd_pc", 16'(instr_pc), 16'(exp_pc));
        check("rnd_instr", instr, exp_instr);
      end
`ifdef IFETCH_LOADER_EN
      if (ld_ready) begin
        check("rnd_ld_we", 16'(mem_we), 16'h1);
        check("rnd_ld_addr", 16'(mem_addr), 16'(ld_addr));
        check("rnd_ld_wdata", 16'(mem_wdata), 16'(ld_data));
        check("rnd_ld_not_valid", 16'(instr_valid), 16'h0);
        if (!ld_valid) check("rnd_ld_unrequested", 16'(ld_ready), 16'h0);
      end else if (mem_we) begin
        check("rnd_we_without_grant", 16'(mem_we), 16'h0);
      end
`else
      if (mem_we) check("rnd_we_tied", 16'(mem_we), 16'h0);
`endif
      if (redirect_valid) exp_pc = redirect_pc;
      else if (instr_valid && instr_ready) exp_pc = exp_pc + 8'd2;
      if (instr_valid && instr_ready) n_acc++;
      @(posedge clk);
      #1;
    end
    check("rnd_progress", 16'(n_acc > 20), 16'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
